clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 72 +++++++
 tb/tb_clk_div_prog.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered divided clock plus a one-cycle tick
// on each rising edge. Ratio is latched only at period boundaries.
//
// Ports:
//   clk, rst (sync, active-high), en (count enable), restart (phase reset)
//   div [CNT_W-1:0]   requested ratio; values below 2 behave as 2
//   clk_div_out       divided clock, high floor(N/2) cycles, low the rest
//   tick              one-cycle pulse with each clk_div_out rise
//   period_cnt [15:0] completed-period counter, present only when the
//                     CLK_DIV_PROG_CNT_EN macro is defined
module clk_div_prog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
`ifdef CLK_DIV_PROG_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             clk_div_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] div_c;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_len;
  logic             wrap;

  assign div_c    = (div < CNT_W'(2)) ? CNT_W'(2) : div;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign high_len = n_act >> 1;
  // n_act is always >= 2, so the subtraction cannot underflow
  assign wrap     = (cnt == n_act - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt         <= '0;
      n_act       <= div_c;
      clk_div_out <= 1'b0;
      tick        <= 1'b0;
    end else if (!en) begin
      tick        <= 1'b0;
    end else if (wrap) begin
      // ratio changes take effect only here, keeping periods glitch-free
      cnt         <= '0;
      n_act       <= div_c;
      clk_div_out <= 1'b1;
      tick        <= 1'b1;
    end else begin
      cnt  <= cnt_inc;
      tick <= 1'b0;
      if (cnt_inc == high_len) begin
        clk_div_out <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_PROG_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      period_cnt <= '0;
    end else if (en && wrap) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: period-level reference model checked every cycle,
// plus directed sequences with hand-computed edge positions.
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         restart = 1'b0;
  logic [W-1:0] div = 8'd4;
  logic         clk_div_out;
  logic         tick;
`ifdef CLK_DIV_PROG_CNT_EN
  logic [15:0]  period_cnt;
  int           m_pc = 0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .restart(restart),
    .div(div),
`ifdef CLK_DIV_PROG_CNT_EN
    .period_cnt(period_cnt),
`endif
    .clk_div_out(clk_div_out),
    .tick(tick)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Reference: position within the current period in enabled edges.
  // A period of n edges ends with a rise; the output then stays high for
  // the first n/2 edges of the next period. Nothing rises before the
  // first complete period after reset/restart.
  int m_n = 2;
  int m_pos = 0;
  bit m_out = 0;
  bit m_tick = 0;
  bit m_rose = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst || restart) begin
      m_n = clampi(int'(div));
      m_pos = 0;
      m_out = 0;
      m_tick = 0;
      m_rose = 0;
`ifdef CLK_DIV_PROG_CNT_EN
      m_pc = 0;
`endif
      m_valid = 1;
    end else if (!en) begin
      m_tick = 0;
    end else begin
      m_pos++;
      m_tick = 0;
      if (m_pos == m_n) begin
        m_pos = 0;
        m_n = clampi(int'(div));
        m_tick = 1;
        m_rose = 1;
`ifdef CLK_DIV_PROG_CNT_EN
        m_pc = (m_pc + 1) % 65536;
`endif
      end
      m_out = m_rose && (m_pos < m_n / 2);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out", int'(clk_div_out), int'(m_out));
      chk("model_tick", int'(tick), int'(m_tick));
`ifdef CLK_DIV_PROG_CNT_EN
      chk("model_pcnt", int'(period_cnt), m_pc);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int d);
    rst = 1'b1;
    restart = 1'b0;
    div = W'(d);
    step(1);
    rst = 1'b0;
    en = 1'b1;
  endtask

  logic [11:0] exp_o4;
  logic [11:0] exp_t4;
  int          dtab[8];

  initial begin
    exp_o4 = 12'd2456;
    exp_t4 = 12'd2184;
    dtab = '{5, 1, 3, 0, 7, 2, 16, 6};

    step(2);
    chk("rst_out", int'(clk_div_out), 0);
    chk("rst_tick", int'(tick), 0);

    rst = 1'b0;
    en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      chk("d4_out", int'(clk_div_out), int'(exp_o4[e-1]));
      chk("d4_tick", int'(tick), int'(exp_t4[e-1]));
    end

    do_reset(3);
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk("d3_out", int'(clk_div_out), int'(e % 3 == 0));
    end

    do_reset(0);
    for (int e = 1; e <= 4; e++) begin
      step(1);
      chk("d0_out", int'(clk_div_out), int'(e % 2 == 0));
    end

    do_reset(1);
    for (int e = 1; e <= 4; e++) begin
      step(1);
      chk("d1_tick", int'(tick), int'(e % 2 == 0));
    end

    do_reset(10);
    for (int e = 1; e <= 18; e++) begin
      if (e == 5) div = 8'd4;
      step(1);
      chk("chg_tick", int'(tick),
          int'(e == 10 || e == 14 || e == 18));
    end

    do_reset(6);
    for (int e = 1; e <= 10; e++) begin
      en = !(e >= 3 && e <= 5);
      step(1);
      chk("gap_tick", int'(tick), int'(e == 9));
      chk("gap_out", int'(clk_div_out), int'(e >= 9));
    end
    en = 1'b1;

    do_reset(8);
    step(4);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("rs_out", int'(clk_div_out), 0);
    for (int e = 1; e <= 10; e++) begin
      step(1);
      chk("rs_tick", int'(tick), int'(e == 8));
    end
    chk("rs_high", int'(clk_div_out), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_out", int'(clk_div_out), 0);
    for (int e = 1; e <= 8; e++) begin
      step(1);
      chk("post_tick", int'(tick), int'(e == 8));
    end
    rst = 1'b1;
    restart = 1'b1;
    step(1);
    rst = 1'b0;
    restart = 1'b0;
    chk("both_out", int'(clk_div_out), 0);
    chk("both_tick", int'(tick), 0);

    for (int i = 0; i < 200; i++) begin
      en = (i % 7 != 3);
      div = W'(dtab[i / 25]);
      restart = (i == 120);
      rst = (i == 170);
      step(1);
    end
    rst = 1'b0;
    restart = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
